if_id_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register for the MIPS32 core. It holds the PC, runs a single-outstanding request/acknowledge handshake to instruction memory, and absorbs hazard-unit stalls with a one-entry skid buffer. It also accepts branch/jump redirects. It presents the registered instruction to decode with pre-split fields, including `id_imm16` and `id_sign_ext_ctrl`, which drive the immediate sign-extension unit directly.

---
 rtl/if_id_stage.sv | 109 ++++++++++
 tb/tb_if_id_stage.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/if_id_stage.sv
// rtl/if_id_stage.sv - MIPS32 instruction fetch stage with IF/ID register and one-entry skid buffer
module if_id_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic [31:0] id_instr,
    output logic [4:0]  id_rs,
    output logic [4:0]  id_rt,
    output logic [4:0]  id_rd,
    output logic [15:0] id_imm16,
    output logic        id_sign_ext_ctrl
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_BUF  = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] drop_addr;
    logic [31:0] buf_instr;
    logic [31:0] buf_pc;
    logic [5:0]  id_opcode;

    // pc already points at the redirect target while DROP waits, so the
    // abandoned address is kept separately to hold imem_addr stable.
    assign imem_req  = rst_n && (state != S_BUF);
    assign imem_addr = (state == S_DROP) ? drop_addr : pc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_REQ;
            pc          <= RESET_PC;
            drop_addr   <= 32'h0;
            buf_instr   <= 32'h0;
            buf_pc      <= 32'h0;
            id_valid    <= 1'b0;
            id_instr    <= 32'h0;
            id_pc       <= 32'h0;
            id_pc_plus4 <= 32'h0;
        end else if (redirect) begin
            pc       <= redirect_pc;
            id_valid <= 1'b0;
            if ((state != S_BUF) && !imem_ack) begin
                state     <= S_DROP;
                drop_addr <= imem_addr;
            end else begin
                state <= S_REQ;
            end
        end else begin
            case (state)
                S_REQ: begin
                    if (imem_ack) begin
                        pc <= pc + 32'd4;
                        if (stall) begin
                            buf_instr <= imem_rdata;
                            buf_pc    <= pc;
                            state     <= S_BUF;
                        end else begin
                            id_valid    <= 1'b1;
                            id_instr    <= imem_rdata;
                            id_pc       <= pc;
                            id_pc_plus4 <= pc + 32'd4;
                        end
                    end else if (!stall) begin
                        id_valid <= 1'b0;
                    end
                end
                S_BUF: begin
                    if (!stall) begin
                        id_valid    <= 1'b1;
                        id_instr    <= buf_instr;
                        id_pc       <= buf_pc;
                        id_pc_plus4 <= buf_pc + 32'd4;
                        state       <= S_REQ;
                    end
                end
                S_DROP: begin
                    if (imem_ack) begin
                        state <= S_REQ;
                    end
                end
                default: state <= S_REQ;
            endcase
        end
    end

    // Fields are slices of the registered word, so they change only with id_instr.
    assign id_opcode        = id_instr[31:26];
    assign id_rs            = id_instr[25:21];
    assign id_rt            = id_instr[20:16];
    assign id_rd            = id_instr[15:11];
    assign id_imm16         = id_instr[15:0];
    assign id_sign_ext_ctrl = !((id_opcode == 6'h0C) || (id_opcode == 6'h0D) || (id_opcode == 6'h0E));

endmodule

// File: tb/tb_if_id_stage.sv
// tb/tb_if_id_stage.sv - self-checking bench for if_id_stage
module tb_if_id_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_rdata;
    logic        stall, redirect;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic [31:0] id_pc, id_pc_plus4, id_instr;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [15:0] id_imm16;
    logic        id_sign_ext_ctrl;

    logic        w_req, w_valid, w_sext;
    logic [31:0] w_addr, w_pc, w_pc4, w_instr;
    logic [4:0]  w_rs, w_rt, w_rd;
    logic [15:0] w_imm;

    int total = 0;
    int bad = 0;
    int lat = 0;
    int cnt = 0;
    logic        ovr_en = 1'b0;
    logic [31:0] ovr_word = 32'h0;

    always #5 clk = ~clk;

    if_id_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_pc(id_pc), .id_pc_plus4(id_pc_plus4), .id_instr(id_instr),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_imm16(id_imm16),
        .id_sign_ext_ctrl(id_sign_ext_ctrl)
    );

    if_id_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .rst_n(rst_n),
        .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_req), .imem_rdata(w_addr ^ 32'hA5A5_0000),
        .stall(1'b0), .redirect(1'b0), .redirect_pc(32'h0),
        .id_valid(w_valid), .id_pc(w_pc), .id_pc_plus4(w_pc4), .id_instr(w_instr),
        .id_rs(w_rs), .id_rt(w_rt), .id_rd(w_rd), .id_imm16(w_imm),
        .id_sign_ext_ctrl(w_sext)
    );

    // Memory model: ack after lat waiting cycles (lat=0 means same-cycle ack).
    always_comb begin
        imem_ack   = imem_req && ((lat == 0) || (cnt == lat));
        imem_rdata = ovr_en ? ovr_word : (imem_addr ^ 32'hA5A5_0000);
    end

    always @(posedge clk) begin
        if (!rst_n || !imem_req || imem_ack) cnt <= 0;
        else cnt <= cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } sb_t;
    sb_t exp_q[$];
    logic drop_pend = 1'b0;
    logic stall_prev = 1'b0;
    logic rst_prev = 1'b0;

    // Scoreboard: accepted responses are queued; every fresh IF/ID load pops one.
    always @(negedge clk) begin
        sb_t e;
        if (!rst_n) begin
            exp_q.delete();
            drop_pend = 1'b0;
        end else begin
            if (id_valid && !stall_prev && rst_prev) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_load", id_pc, 32'hXXXX_XXXX);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_pc", id_pc, e.pc);
                    check("sb_instr", id_instr, e.instr);
                    check("sb_pc4", id_pc_plus4, e.pc + 32'd4);
                end
            end
            if (imem_ack) begin
                if (redirect || drop_pend) drop_pend = 1'b0;
                else begin
                    e.pc = imem_addr;
                    e.instr = imem_rdata;
                    exp_q.push_back(e);
                end
            end
            if (redirect && imem_req && !imem_ack) drop_pend = 1'b1;
        end
        stall_prev = stall;
        rst_prev = rst_n;
    end

    typedef struct {
        logic [31:0] word;
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        logic        sext;
    } dec_vec_t;
    dec_vec_t vecs[7];

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic found;
        vecs[0] = '{32'h3C08_8001, 5'd0,  5'd8,  5'd16, 16'h8001, 1'b1};
        vecs[1] = '{32'h3508_FFFF, 5'd8,  5'd8,  5'd31, 16'hFFFF, 1'b0};
        vecs[2] = '{32'h3109_00FF, 5'd8,  5'd9,  5'd0,  16'h00FF, 1'b0};
        vecs[3] = '{32'h3A52_1234, 5'd18, 5'd18, 5'd2,  16'h1234, 1'b0};
        vecs[4] = '{32'h2508_FFFE, 5'd8,  5'd8,  5'd31, 16'hFFFE, 1'b1};
        vecs[5] = '{32'h0149_5820, 5'd10, 5'd9,  5'd11, 16'h5820, 1'b1};
        vecs[6] = '{32'h3000_0000, 5'd0,  5'd0,  5'd0,  16'h0000, 1'b0};

        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        repeat (3) tick();
        @(negedge clk);
        check("rst_req", imem_req, 0);
        check("rst_valid", id_valid, 0);
        check("rst_pc", id_pc, 0);
        check("rst_instr", id_instr, 0);

        // Reset release, zero-wait fetch stream
        tick(); rst_n = 1'b1;
        @(negedge clk);
        check("c0_req", imem_req, 1);
        check("c0_addr", imem_addr, 32'h0);
        check("c0_valid", id_valid, 0);
        check("w_c0_addr", w_addr, 32'hFFFF_FFFC);
        tick();
        @(negedge clk);
        check("c1_addr", imem_addr, 32'h4);
        check("c1_valid", id_valid, 1);
        check("c1_pc", id_pc, 32'h0);
        check("w_c1_addr", w_addr, 32'h0);
        check("w_c1_pc", w_pc, 32'hFFFF_FFFC);
        check("w_c1_pc4", w_pc4, 32'h0);

        // Stall for 3 cycles while pc=8 is acked
        tick(); stall = 1'b1;
        @(negedge clk);
        check("st0_addr", imem_addr, 32'h8);
        check("st0_pc", id_pc, 32'h4);
        tick();
        @(negedge clk);
        check("st1_req", imem_req, 0);
        check("st1_pc", id_pc, 32'h4);
        tick();
        @(negedge clk);
        check("st2_pc", id_pc, 32'h4);
        tick(); stall = 1'b0;
        @(negedge clk);
        check("st3_req", imem_req, 0);
        tick(); lat = 3;
        @(negedge clk);
        check("st4_pc", id_pc, 32'h8);
        check("st4_valid", id_valid, 1);
        check("st4_addr", imem_addr, 32'hC);

        // Redirect while the slow fetch of pc=12 is outstanding
        tick(); redirect = 1'b1; redirect_pc = 32'h0000_0100;
        @(negedge clk);
        tick(); redirect = 1'b0;
        @(negedge clk);
        check("dr0_addr", imem_addr, 32'hC);
        check("dr0_valid", id_valid, 0);
        tick();
        @(negedge clk);
        check("dr1_addr", imem_addr, 32'hC);
        check("dr1_ack", imem_ack, 1);
        tick(); lat = 0;
        @(negedge clk);
        check("dr2_addr", imem_addr, 32'h100);
        check("dr2_valid", id_valid, 0);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            @(negedge clk);
            found = id_valid;
        end
        check("dr_wait", found, 1);
        check("dr_first_pc", id_pc, 32'h100);

        // Redirect together with stall and a zero-wait ack
        tick(); redirect = 1'b1; stall = 1'b1; redirect_pc = 32'h300;
        @(negedge clk);
        check("rs_ack", imem_ack, 1);
        tick(); redirect = 1'b0; stall = 1'b0;
        @(negedge clk);
        check("rs_valid", id_valid, 0);
        check("rs_addr", imem_addr, 32'h300);
        tick(); redirect = 1'b1; redirect_pc = 32'h400;
        @(negedge clk);
        tick(); redirect = 1'b0;
        @(negedge clk);
        check("ra_valid", id_valid, 0);
        check("ra_addr", imem_addr, 32'h400);

        // Decode table
        ovr_en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            ovr_word = vecs[i].word;
            @(negedge clk);
            tick();
            @(negedge clk);
            check("dec_instr", id_instr, vecs[i].word);
            check("dec_rs", {27'h0, id_rs}, {27'h0, vecs[i].rs});
            check("dec_rt", {27'h0, id_rt}, {27'h0, vecs[i].rt});
            check("dec_rd", {27'h0, id_rd}, {27'h0, vecs[i].rd});
            check("dec_imm", {16'h0, id_imm16}, {16'h0, vecs[i].imm});
            check("dec_sext", {31'h0, id_sign_ext_ctrl}, {31'h0, vecs[i].sext});
        end
        ovr_en = 1'b0;

        // Reset pulsed while a word sits in the skid buffer
        tick(); stall = 1'b1;
        @(negedge clk);
        tick();
        @(negedge clk);
        check("rb_req", imem_req, 0);
        tick(); rst_n = 1'b0; stall = 1'b0;
        @(negedge clk);
        check("rb_req_rst", imem_req, 0);
        tick(); rst_n = 1'b1;
        @(negedge clk);
        check("rb_valid", id_valid, 0);
        check("rb_req_post", imem_req, 1);
        check("rb_addr", imem_addr, 32'h0);
        tick();
        @(negedge clk);
        check("rb_pc", id_pc, 32'h0);
        tick();
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
